ssb_drive_seq: RTL and testbench
================================

Name: ssb_drive_seq

Overview:
- Soft-start/soft-stop sequencer for the SSB output path. It sits between the feedback drive source and the SSB output block.
- It scales the interleaved I/Q drive word by a slewed gain and generates that block's enable.
- A trip input forces the output off at once.
- The gain ramps up and down so the DACs never see an amplitude step on turn-on, turn-off or setpoint change.

Parameters:
GW, 17, gain width (unsigned; 2^GW-1 = unity)
SW, 16, step width (unsigned)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
iq  in  1  I/Q phase (div_state[0]); 1 marks the Q sample
drive_in  in  18  signed interleaved I/Q drive from feedback
setpoint  in  GW  target gain, unsigned
step  in  SW  gain increment per update tick
start  in  1  request ramp-up (level or pulse)
stop  in  1  request ramp-down
trip  in  1  interlock; level-sensitive, highest priority
clear  in  1  leave TRIPPED
drive_out  out  18  signed scaled drive, to SSB output drive
enable  out  1  to SSB output enable
state  out  3  IDLE=0, SLEW=1, ON=2, DOWN=3, TRIPPED=4
at_setpoint  out  1  gain==setpoint and state==ON
tripped  out  1  state==TRIPPED

Behaviour:
- Reset: state=IDLE, gain=0, drive_out=0, enable=0, at_setpoint=0, tripped=0. All pipeline registers are cleared. Reset mid-ramp aborts the ramp with no ramp-down.
- Update tick: the cycle where iq==1. The gain register changes only at the end of a tick cycle, so each I/Q pair uses one gain value.
- Priority, evaluated every cycle: trip > stop > start.
- IDLE: gain=0.
  - start & ~trip -> SLEW.
- SLEW: on each tick, gain moves toward setpoint by step, saturating exactly at setpoint in both directions.
  - gain==setpoint -> ON.
  - step==0: gain loads setpoint directly on the next tick.
- ON: gain is held.
  - setpoint!=gain -> SLEW (re-slew).
  - start is ignored.
- stop in SLEW or ON -> DOWN.
- DOWN: on each tick, gain = max(gain-step, 0); step==0 loads 0.
  - gain==0 -> IDLE.
  - start & ~stop in DOWN -> SLEW (reversal from the current gain, no discontinuity).
- trip, any state except TRIPPED -> TRIPPED next cycle.
  - gain is forced to 0 and drive_out=0 the cycle after trip is sampled, bypassing the pipeline.
  - enable=0 on the same cycle.
- TRIPPED: clear & ~trip -> IDLE. start, stop and setpoint are ignored.
- Datapath:
  - p = drive_in * {1'b0, gain} (signed 36-bit), registered.
  - drive_out = p >>> GW, truncated toward -inf, registered. Latency is 2 clk from drive_in.
  - Gain is at most 2^GW-1, so the result is always within 18 bits and never overflows. -131072 at full gain gives -131071.
- enable:
  - rises 2 clk after leaving IDLE, aligned with the first scaled sample.
  - falls 2 clk after DOWN reaches IDLE, after the last zero-gain sample.
  - except on trip, where it falls after 1 clk as above.
- Both pipeline stages are zeroed in TRIPPED and IDLE.
- at_setpoint and tripped are registered, updating with state.
- A setpoint change during DOWN is ignored.

Test Plan:
- Reset, then start with setpoint=100000, step=10000, drive_in alternating I=+131071 / Q=-131072 -> gain follows 10000, 20000 … 100000 over 10 ticks (20 clk); state reaches ON; at_setpoint=1; drive_out I=99999, Q=-100000; enable high 2 clk after start.
- From ON, stop with step=30000 -> gain follows 70000, 40000, 10000, 0; state reaches IDLE; enable falls 2 clk after reaching IDLE; drive_out=0.
- Trip asserted mid-SLEW at gain=50000 -> next cycle drive_out=0, enable=0, state=4, tripped=1; clear while trip is still high -> stays 4; trip low then clear -> IDLE.
- start, stop and trip asserted together from IDLE -> TRIPPED; start+stop from IDLE -> stays IDLE.
- In ON at 100000, setpoint changed to 40000 with step=25000 -> gain follows 75000, 50000, 40000 (saturates exactly); returns to ON.
- step=0 with setpoint=65536 -> gain=65536 after one tick; DOWN -> 0 after one tick; start during DOWN at gain=30000 with step=5000 -> gain 35000, no dip.

Source files
------------

// File: rtl/ssb_drive_seq_if.sv
// ssb_drive_seq_if: drive path and control bundle between feedback source, sequencer and SSB output block
interface ssb_drive_seq_if #(parameter int GW = 17, parameter int SW = 16);
  logic iq;
  logic signed [17:0] drive_in;
  logic [GW-1:0] setpoint;
  logic [SW-1:0] step;
  logic start;
  logic stop;
  logic trip;
  logic clear;
  logic signed [17:0] drive_out;
  logic enable;
  logic [2:0] state;
  logic at_setpoint;
  logic tripped;
  modport master (
    output iq, drive_in, setpoint, step, start, stop, trip, clear,
    input drive_out, enable, state, at_setpoint, tripped
  );
  modport slave (
    input iq, drive_in, setpoint, step, start, stop, trip, clear,
    output drive_out, enable, state, at_setpoint, tripped
  );
endinterface

// File: rtl/ssb_drive_seq.sv
// ssb_drive_seq: soft-start/stop gain sequencer scaling the interleaved I/Q drive and gating the SSB output enable
module ssb_drive_seq #(
  parameter int GW = 17,
  parameter int SW = 16
) (
  input logic clk,
  input logic reset,
  ssb_drive_seq_if.slave io
);
  localparam logic [2:0] IDLE = 3'd0, SLEW = 3'd1, ON = 3'd2, DOWN = 3'd3, TRIPPED = 3'd4;
  logic [2:0] state, state_n;
  logic [GW-1:0] gain, gain_n, stp, slew_g, down_g;
  logic [GW:0] up;
  logic signed [GW+18:0] p;
  logic signed [17:0] drive_out;
  logic go, zero, en1, enable, at_setpoint, tripped;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    go = io.start & ~io.stop;
    state_n = io.trip ? TRIPPED :
      state == TRIPPED ? (io.clear ? IDLE : TRIPPED) :
      state == IDLE ? (go ? SLEW : IDLE) :
      state == DOWN ? (go ? SLEW : gain == '0 ? IDLE : DOWN) :
      io.stop ? DOWN : gain == io.setpoint ? ON : SLEW;
  end
  always_comb begin
    stp = GW'(io.step);
    up = {1'b0, gain} + {1'b0, stp};
    slew_g = io.step == '0 ? io.setpoint :
      gain < io.setpoint ? (up >= {1'b0, io.setpoint} ? io.setpoint : up[GW-1:0]) :
      (gain - io.setpoint <= stp ? io.setpoint : gain - stp);
    down_g = (io.step == '0 || stp >= gain) ? '0 : gain - stp;
    zero = io.trip || state == IDLE || state == TRIPPED;
    gain_n = zero ? '0 : !io.iq ? gain : state == SLEW ? slew_g : state == DOWN ? down_g : gain;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gain <= '0;
      p <= '0;
      drive_out <= '0;
      en1 <= 1'b0;
      enable <= 1'b0;
      at_setpoint <= 1'b0;
      tripped <= 1'b0;
    end else begin
      gain <= gain_n;
      p <= zero ? '0 : (GW+19)'(io.drive_in) * (GW+19)'($signed({1'b0, gain}));
      drive_out <= zero ? '0 : 18'(p >>> GW);
      en1 <= ~zero;
      enable <= ~io.trip & en1;
      at_setpoint <= state_n == ON && gain_n == io.setpoint;
      tripped <= state_n == TRIPPED;
    end
  end
  assign io.drive_out = drive_out;
  assign io.enable = enable;
  assign io.state = state;
  assign io.at_setpoint = at_setpoint;
  assign io.tripped = tripped;
endmodule

// File: tb/tb_ssb_drive_seq.sv
// tb_ssb_drive_seq: directed and randomized checks of the SSB drive sequencer against a cycle model
module tb_ssb_drive_seq;
  localparam int M_IDLE = 0, M_SLEW = 1, M_ON = 2, M_DOWN = 3, M_TRIP = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  ssb_drive_seq_if bus();
  ssb_drive_seq dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  int ntests = 0;
  int nfail = 0;
  bit rnd_drive = 1'b0;
  int m_mode = 0, m_gain = 0, m_stage = 0, m_out = 0;
  bit m_en = 1'b0, m_act = 1'b0, m_at = 1'b0, m_tr = 1'b0;
  function automatic int imin(int a, int b);
    return a < b ? a : b;
  endfunction
  function automatic int imax(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int scaled(int d, int g);
    longint pr, q;
    pr = longint'(d) * longint'(g);
    q = pr / 131072;
    if (pr < 0 && q * 131072 != pr) q = q - 1;
    return int'(q);
  endfunction
  function automatic logic [23:0] obs();
    return {bus.drive_out, bus.enable, bus.state, bus.at_setpoint, bus.tripped};
  endfunction
  function automatic logic [23:0] expv();
    return {18'(m_out), m_en, 3'(m_mode), m_at, m_tr};
  endfunction
  task automatic model_step();
    int d, sp, st, ng, nm;
    bit z, go;
    d = int'(bus.drive_in);
    sp = int'(bus.setpoint);
    st = int'(bus.step);
    if (reset) begin
      m_mode = M_IDLE; m_gain = 0; m_stage = 0; m_out = 0;
      m_en = 0; m_act = 0; m_at = 0; m_tr = 0;
      return;
    end
    z = bus.trip || m_mode == M_IDLE || m_mode == M_TRIP;
    m_out = z ? 0 : m_stage;
    m_stage = z ? 0 : scaled(d, m_gain);
    m_en = !bus.trip && m_act;
    m_act = !z;
    if (z) ng = 0;
    else if (!bus.iq) ng = m_gain;
    else if (m_mode == M_SLEW) ng = st == 0 ? sp : (m_gain < sp ? imin(m_gain + st, sp) : imax(m_gain - st, sp));
    else if (m_mode == M_DOWN) ng = st == 0 ? 0 : imax(m_gain - st, 0);
    else ng = m_gain;
    go = bus.start && !bus.stop;
    if (bus.trip) nm = M_TRIP;
    else case (m_mode)
      M_IDLE: nm = go ? M_SLEW : M_IDLE;
      M_DOWN: nm = go ? M_SLEW : (m_gain == 0 ? M_IDLE : M_DOWN);
      M_TRIP: nm = bus.clear ? M_IDLE : M_TRIP;
      default: nm = bus.stop ? M_DOWN : (m_gain == sp ? M_ON : M_SLEW);
    endcase
    m_at = nm == M_ON && ng == sp;
    m_tr = nm == M_TRIP;
    m_mode = nm;
    m_gain = ng;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bus.iq = ~bus.iq;
    bus.drive_in = rnd_drive ? 18'($urandom) : (bus.iq ? 18'h20000 : 18'h1FFFF);
  endtask
  task automatic test_reset();
    reset = 1; bus.start = 1; bus.setpoint = 17'd100000; bus.step = 16'd5000;
    repeat (3) tick();
    ntests++; if (obs() !== 24'h0) begin nfail++; $display("FAIL reset_state got %h exp %h", obs(), 24'h0); end
    reset = 0; bus.start = 0;
    tick();
    ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL reset_release got %h exp %h", obs(), expv()); end
  endtask
  task automatic test_ramp();
    int a, b;
    bus.setpoint = 17'd100000; bus.step = 16'd10000; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 1; i < 26; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL ramp cyc%0d got %h exp %h", i, obs(), expv()); end
      if (i == 1) begin ntests++; if (bus.enable !== 1'b0) begin nfail++; $display("FAIL ramp_enable_early got %b exp 0", bus.enable); end end
      if (i == 2) begin ntests++; if (bus.enable !== 1'b1) begin nfail++; $display("FAIL ramp_enable_rise got %b exp 1", bus.enable); end end
    end
    ntests++; if (bus.state !== 3'd2 || bus.at_setpoint !== 1'b1) begin nfail++; $display("FAIL ramp_on got st=%0d as=%b exp st=2 as=1", bus.state, bus.at_setpoint); end
    tick(); a = int'(bus.drive_out);
    tick(); b = int'(bus.drive_out);
    ntests++; if (!((a == 99999 && b == -100000) || (a == -100000 && b == 99999))) begin nfail++; $display("FAIL ramp_scale got %0d,%0d exp 99999/-100000", a, b); end
  endtask
  task automatic test_stop();
    bus.step = 16'd30000; bus.stop = 1;
    tick();
    bus.stop = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL stop cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    ntests++; if (bus.state !== 3'd0 || bus.drive_out !== 18'sd0 || bus.enable !== 1'b0) begin nfail++; $display("FAIL stop_idle got st=%0d out=%0d en=%b exp 0/0/0", bus.state, bus.drive_out, bus.enable); end
  endtask
  task automatic test_trip();
    bus.setpoint = 17'd100000; bus.step = 16'd10000; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 40 && m_gain != 50000; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL trip_ramp cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    bus.trip = 1;
    tick();
    ntests++; if (obs() !== 24'h000011) begin nfail++; $display("FAIL trip_force got %h exp %h", obs(), 24'h000011); end
    bus.clear = 1;
    tick();
    ntests++; if (bus.state !== 3'd4) begin nfail++; $display("FAIL trip_hold got %0d exp 4", bus.state); end
    bus.trip = 0;
    tick();
    ntests++; if (bus.state !== 3'd0 || bus.tripped !== 1'b0) begin nfail++; $display("FAIL trip_clear got st=%0d tr=%b exp 0/0", bus.state, bus.tripped); end
    bus.clear = 0;
    repeat (3) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL trip_after got %h exp %h", obs(), expv()); end
    end
  endtask
  task automatic test_combo();
    bus.start = 1; bus.stop = 1; bus.trip = 1;
    tick();
    ntests++; if (bus.state !== 3'd4) begin nfail++; $display("FAIL combo_trip got %0d exp 4", bus.state); end
    bus.start = 0; bus.stop = 0; bus.trip = 0; bus.clear = 1;
    tick();
    bus.clear = 0;
    ntests++; if (bus.state !== 3'd0) begin nfail++; $display("FAIL combo_clear got %0d exp 0", bus.state); end
    bus.start = 1; bus.stop = 1;
    repeat (2) tick();
    ntests++; if (bus.state !== 3'd0 || bus.enable !== 1'b0) begin nfail++; $display("FAIL combo_startstop got st=%0d en=%b exp 0/0", bus.state, bus.enable); end
    bus.start = 0; bus.stop = 0;
  endtask
  task automatic test_fullscale();
    int a, b;
    bus.setpoint = 17'h1FFFF; bus.step = 16'd0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL full cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    tick(); a = int'(bus.drive_out);
    tick(); b = int'(bus.drive_out);
    ntests++; if (!((a == 131070 && b == -131071) || (a == -131071 && b == 131070))) begin nfail++; $display("FAIL full_scale got %0d,%0d exp 131070/-131071", a, b); end
    bus.stop = 1;
    tick();
    bus.stop = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL full_down cyc%0d got %h exp %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_reslew();
    int a, b;
    bus.setpoint = 17'd100000; bus.step = 16'd25000; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL reslew_up cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    ntests++; if (bus.state !== 3'd2) begin nfail++; $display("FAIL reslew_on1 got %0d exp 2", bus.state); end
    bus.setpoint = 17'd40000;
    for (int i = 0; i < 14; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL reslew_dn cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    ntests++; if (bus.state !== 3'd2 || bus.at_setpoint !== 1'b1) begin nfail++; $display("FAIL reslew_on2 got st=%0d as=%b exp 2/1", bus.state, bus.at_setpoint); end
    tick(); a = int'(bus.drive_out);
    tick(); b = int'(bus.drive_out);
    ntests++; if (!((a == 39999 && b == -40000) || (a == -40000 && b == 39999))) begin nfail++; $display("FAIL reslew_scale got %0d,%0d exp 39999/-40000", a, b); end
  endtask
  task automatic test_step0();
    int a, b, minpos;
    bit seen;
    bus.step = 16'd0; bus.stop = 1;
    tick();
    bus.stop = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL step0_down cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    ntests++; if (bus.state !== 3'd0) begin nfail++; $display("FAIL step0_idle got %0d exp 0", bus.state); end
    bus.setpoint = 17'd65536; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL step0_up cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    tick(); a = int'(bus.drive_out);
    tick(); b = int'(bus.drive_out);
    ntests++; if (!((a == 65535 && b == -65536) || (a == -65536 && b == 65535))) begin nfail++; $display("FAIL step0_scale got %0d,%0d exp 65535/-65536", a, b); end
    bus.setpoint = 17'd30000; bus.step = 16'd30000;
    for (int i = 0; i < 8; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL rev_settle cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    if (bus.iq == 1'b0) tick();
    bus.stop = 1;
    tick();
    bus.stop = 0; bus.start = 1; bus.setpoint = 17'd65536; bus.step = 16'd5000;
    tick();
    bus.start = 0;
    minpos = 1 << 30; seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL rev cyc%0d got %h exp %h", i, obs(), expv()); end
      if (bus.drive_out > 0) minpos = imin(minpos, int'(bus.drive_out));
      if (bus.drive_out == 18'sd34999) seen = 1;
    end
    ntests++; if (minpos < 29999 || !seen) begin nfail++; $display("FAIL rev_nodip got min=%0d seen35k=%b exp min>=29999 seen=1", minpos, seen); end
    bus.step = 16'd0; bus.stop = 1;
    tick();
    bus.stop = 0;
    repeat (6) tick();
  endtask
  task automatic test_random();
    rnd_drive = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.start = $urandom_range(0, 9) == 0;
      bus.stop = $urandom_range(0, 19) == 0;
      bus.trip = $urandom_range(0, 49) == 0;
      bus.clear = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 29) == 0) bus.setpoint = $urandom_range(0, 3) == 0 ? 17'h1FFFF : 17'($urandom);
      if ($urandom_range(0, 29) == 0) bus.step = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom);
      reset = $urandom_range(0, 499) == 0;
      tick();
      ntests++; if (obs() !== expv()) begin nfail++; $display("FAIL random cyc%0d got %h exp %h", i, obs(), expv()); end
    end
    reset = 0;
  endtask
  initial begin
    bus.iq = 0; bus.drive_in = 18'h1FFFF; bus.setpoint = '0; bus.step = '0;
    bus.start = 0; bus.stop = 0; bus.trip = 0; bus.clear = 0;
    test_reset();
    test_ramp();
    test_stop();
    test_trip();
    test_combo();
    test_fullscale();
    test_reslew();
    test_step0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
